fetch_queue: RTL



---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_fifo.sv | 60 ++++++
 rtl/fetch_queue.sv | 107 ++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage: the queue entry format and
// the word-alignment helper used for fetch and redirect addresses.
package fetch_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_ALIGN = 4;

  typedef struct packed {
    logic [XLEN-1:0] data;
    logic [XLEN-1:0] addr;
    logic            half_start;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// In-order FIFO of fetch entries with a registered head; clear wins over
// push and pop so a flush leaves the queue empty regardless of traffic.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clear,
  input  logic         push,
  input  fetch_entry_t din,
  input  logic         pop,
  output fetch_entry_t head,
  output logic         full,
  output logic         empty,
  output logic [CW-1:0] count
);

  fetch_entry_t   mem [DEPTH];
  fetch_entry_t   head_q;
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW-1:0]  rd_next;
  logic           do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign rd_next = rd_ptr + AW'(do_pop);
  assign head    = head_q;

  // NOTE: the storage array has no reset; count and head_q alone define what is valid.
  always_ff @(posedge clk_i) begin
    if (push && !clear) mem[wr_ptr] <= din;
  end

  // The head register tracks the entry at the post-update read pointer; when
  // that slot is being written this cycle, the incoming entry bypasses the array.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head_q <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      rd_ptr <= rd_next;
      count  <= count + CW'(push) - CW'(do_pop);
      head_q <= (push && (wr_ptr == rd_next)) ? din : mem[rd_next];
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// Fetch stage: issues word-aligned requests under a credit limit, queues
// in-order responses for the re-aligner, and drops stale responses after a flush.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] flush_pc_i,
  output logic            req_valid_o,
  input  logic            req_ready_i,
  output logic [XLEN-1:0] req_addr_o,
  input  logic            rsp_valid_i,
  input  logic [XLEN-1:0] rsp_data_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] data_o,
  output logic [XLEN-1:0] addr_o,
  output logic            half_start_o,
  output logic            empty_o
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   outstanding_next;
  logic [CW-1:0]   discard;
  logic [CW-1:0]   fifo_count;
  logic [CW:0]     in_use;
  logic [XLEN-1:0] rsp_addr;
  logic            half_pending;
  logic            req_fire;
  logic            rsp_keep;
  logic            pop;
  logic            fifo_full;
  logic            fifo_empty;
  fetch_entry_t    push_entry;
  fetch_entry_t    head;

  // Every queued entry and every in-flight request holds one credit, so the
  // FIFO can always absorb all outstanding responses.
  assign in_use      = {1'b0, fifo_count} + {1'b0, outstanding};
  assign req_valid_o = !rst_i && !flush_i && (in_use < (CW + 1)'(DEPTH));
  assign req_fire    = req_valid_o && req_ready_i;
  assign rsp_keep    = rsp_valid_i && !flush_i && (discard == '0);
  assign pop         = valid_o && ready_i && !flush_i;

  assign outstanding_next = outstanding + CW'(req_fire) - CW'(rsp_valid_i);

  assign push_entry = '{data: rsp_data_i, addr: rsp_addr, half_start: half_pending};

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clear (flush_i),
    .push  (rsp_keep),
    .din   (push_entry),
    .pop   (pop),
    .head  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign valid_o      = !fifo_empty;
  assign empty_o      = fifo_empty;
  assign data_o       = head.data;
  assign addr_o       = head.addr;
  assign half_start_o = head.half_start;

  // NOTE: sequential state uses non-blocking assignments so every update reads pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      req_addr_o   <= RESET_PC;
      rsp_addr     <= RESET_PC;
      outstanding  <= '0;
      discard      <= '0;
      half_pending <= 1'b0;
    end else begin
      outstanding <= outstanding_next;
      if (flush_i) begin
        // Everything still in flight after this cycle belongs to the old path.
        req_addr_o   <= word_align(flush_pc_i);
        rsp_addr     <= word_align(flush_pc_i);
        discard      <= outstanding_next;
        half_pending <= flush_pc_i[1];
      end else begin
        if (req_fire) req_addr_o <= req_addr_o + XLEN'(INSTR_ALIGN);
        if (rsp_valid_i && (discard != '0)) discard <= discard - 1'b1;
        if (rsp_keep) begin
          rsp_addr     <= rsp_addr + XLEN'(INSTR_ALIGN);
          half_pending <= 1'b0;
        end
      end
    end
  end

  a_no_push_when_full: assert property (@(posedge clk_i) disable iff (rst_i)
    !(rsp_keep && fifo_full));

  a_flush_pc_halfword: assert property (@(posedge clk_i) disable iff (rst_i)
    !(flush_i && flush_pc_i[0]));

endmodule
